mem_responder: RTL

- Memory-side responder that serves CPU data/instruction requests over a valid/ready request channel and returns a one-cycle response pulse.
- Owns a word-organised RAM and performs word, byte and halfword reads/writes. Sub-word stores use an internal read-modify-write.
- Adds a programmable wait-state count so the multicycle control FSM can be exercised against a non-zero-latency memory.
- Sits between the core's address/write-data/size outputs and the memory-data input path.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Wait-stated memory responder: word/byte/halfword access with sub-word read-modify-write.
// Optional MEM_ALIGN_CHECK_EN flags misaligned word/halfword requests as errors.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {StIdle, StWait, StAccess, StMerge, StResp} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         buf_q;
    logic [31:0]         ram [DEPTH];

    logic [IDX_W-1:0]    idx;
    logic                misalign;
    logic [31:0]         shifted;
    logic [31:0]         rd_lane;
    logic [31:0]         merged;
    logic                ram_we;
    logic [31:0]         ram_wdata;

    assign idx       = addr_q[ADDR_W-1:2];
    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((req_size == 2'd0) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'd2) && req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    assign shifted = buf_q >> {addr_q[1:0], 3'b000};

    // Little-endian lane extraction, zero-extended
    always_comb begin
        rd_lane = buf_q;
        case (size_q)
            2'd1:    rd_lane = {24'h0, shifted[7:0]};
            2'd2:    rd_lane = addr_q[1] ? {16'h0, buf_q[31:16]} : {16'h0, buf_q[15:0]};
            default: rd_lane = buf_q;
        endcase
    end

    always_comb begin
        merged = buf_q;
        if (size_q == 2'd1) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Word writes commit in ACCESS, sub-word writes in MERGE; size 3 never gets here
    always_comb begin
        ram_we    = ((state == StAccess) && wr_q && (size_q == 2'd0)) || (state == StMerge);
        ram_wdata = (state == StMerge) ? merged : wdata_q;
    end

    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[idx] <= ram_wdata;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            buf_q     <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        wr_q    <= req_wr;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        if ((req_size == 2'd3) || misalign) begin
                            err_q <= 1'b1;
                            state <= StResp;
                        end else begin
                            err_q <= 1'b0;
                            if (WAIT_CYCLES == 0) begin
                                state <= StAccess;
                            end else begin
                                cnt   <= 4'(WAIT_CYCLES);
                                state <= StWait;
                            end
                        end
                    end
                end
                StWait: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= StAccess;
                    end
                end
                StAccess: begin
                    buf_q <= ram[idx];
                    if (wr_q && (size_q != 2'd0)) begin
                        state <= StMerge;
                    end else begin
                        state <= StResp;
                    end
                end
                StMerge: begin
                    state <= StResp;
                end
                StResp: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= err_q ? 32'h0 : (wr_q ? buf_q : rd_lane);
                    state     <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
